// File: rtl/vc_plane_buffer.sv
// vc_plane_buffer: per-VC input FIFOs steered by VC tag, drained by the plane selector
module vc_plane_buffer #(
  parameter int VC = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [VC:0]           in_vc,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VC:0]           VCPlaneSelector,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [VC:0]           out_vc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [VC-1:0]         vc_full,
  output logic [VC-1:0]         vc_empty,
  output logic                  drop_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = VC > 1 ? $clog2(VC) : 1;
  logic [DATA_WIDTH-1:0] mem [VC][DEPTH];
  logic [AW-1:0] wptr [VC];
  logic [AW-1:0] rptr [VC];
  logic [CW-1:0] cnt [VC];
  logic in_ok, sel_ok, we, re;
  logic [IW-1:0] wi, si;
  assign in_ok = in_vc < (VC+1)'(VC);
  assign sel_ok = VCPlaneSelector < (VC+1)'(VC);
  assign wi = in_vc[IW-1:0];
  assign si = VCPlaneSelector[IW-1:0];
  assign in_ready = !in_ok || !vc_full[wi];
  assign we = in_valid && in_ok && !vc_full[wi];
  assign out_valid = sel_ok && !vc_empty[si];
  assign out_data = sel_ok ? mem[si][rptr[si]] : '0;
  assign out_vc = VCPlaneSelector;
  assign re = out_valid && out_ready;
  always_comb begin
    vc_full = '0;
    vc_empty = '0;
    for (int i = 0; i < VC; i++) begin
      vc_full[i] = cnt[i] == CW'(DEPTH);
      vc_empty[i] = cnt[i] == '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VC; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i] <= '0;
      end
      drop_err <= 1'b0;
    end else begin
      for (int i = 0; i < VC; i++) begin
        if (we && wi == IW'(i)) wptr[i] <= wptr[i] + 1'b1;
        if (re && si == IW'(i)) rptr[i] <= rptr[i] + 1'b1;
        cnt[i] <= cnt[i] + CW'(we && wi == IW'(i)) - CW'(re && si == IW'(i));
      end
      drop_err <= in_valid && !in_ok;
    end
  end
  // storage is deliberately left unreset; counts alone define validity
  always_ff @(posedge clk) begin
    for (int i = 0; i < VC; i++)
      if (we && wi == IW'(i)) mem[i][wptr[i]] <= in_data;
  end
endmodule

// File: tb/tb_vc_plane_buffer.sv
// tb_vc_plane_buffer: randomized and directed checks against a queue-based model
module tb_vc_plane_buffer;
  logic clk = 0, rst = 0;
  logic [31:0] in_data = 0, out_data;
  logic [4:0] in_vc = 0, sel = 0, out_vc;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, drop_err;
  logic [3:0] vc_full, vc_empty;
  logic [31:0] q [4][$];
  int total = 0, bad = 0;
  vc_plane_buffer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vc(in_vc), .in_valid(in_valid),
    .in_ready(in_ready), .VCPlaneSelector(sel), .out_data(out_data), .out_vc(out_vc),
    .out_valid(out_valid), .out_ready(out_ready), .vc_full(vc_full), .vc_empty(vc_empty),
    .drop_err(drop_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic check_outputs();
    logic [3:0] ee, ef;
    logic ev;
    for (int i = 0; i < 4; i++) begin
      ee[i] = q[i].size() == 0;
      ef[i] = q[i].size() == 4;
    end
    ev = sel < 4 && q[sel].size() > 0;
    chk("in_ready", in_ready, in_vc >= 4 || q[in_vc].size() < 4);
    chk("out_valid", out_valid, ev);
    if (ev) chk("out_data", out_data, q[sel][0]);
    else if (sel >= 4) chk("out_data_oor", out_data, 0);
    chk("out_vc", out_vc, sel);
    chk("vc_empty", vc_empty, ee);
    chk("vc_full", vc_full, ef);
  endtask
  task automatic step(input logic v, input logic [4:0] vc, input logic [31:0] d,
                      input logic [4:0] s, input logic ordy);
    logic wr, rd, drop;
    @(negedge clk);
    in_valid = v; in_vc = vc; in_data = d; sel = s; out_ready = ordy;
    #1;
    check_outputs();
    wr = v && vc < 4 && q[vc].size() < 4;
    rd = ordy && s < 4 && q[s].size() > 0;
    drop = v && vc >= 4;
    @(posedge clk);
    #1;
    if (rd) void'(q[s].pop_front());
    if (wr) q[vc].push_back(d);
    chk("drop_err", drop_err, drop);
  endtask
  initial begin
    #2;
    chk("rst_empty", vc_empty, 4'hF);
    chk("rst_full", vc_full, 4'h0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    @(negedge clk); rst = 1;
    step(1, 2, 32'hA0, 0, 1);
    step(1, 2, 32'hA1, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("vc2_only", vc_empty, 4'b1011);
    step(0, 0, 0, 2, 1);
    step(0, 0, 0, 2, 1);
    step(0, 0, 0, 2, 0);
    chk("drained", vc_empty, 4'hF);
    for (int i = 0; i < 4; i++) step(1, 1, 32'hB0 + i, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("full1", vc_full[1], 1);
    step(0, 0, 0, 0, 0);
    step(1, 1, 32'hBF, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("refused_not_full", vc_full[1], 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
    step(1, 3, 32'hC0, 4, 0);
    for (int i = 1; i < 10; i++) step(1, 3, 32'hC0 + i, 3, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 3, 1);
    for (int v = 0; v < 4; v++) step(1, v[4:0], 32'hD0 + v, 4, 0);
    for (int v = 0; v < 4; v++) step(1, v[4:0], 32'hE0 + v, 4, 0);
    for (int v = 0; v < 4; v++) step(0, 0, 0, v[4:0], 1);
    step(1, 5, 32'hDEAD, 4, 1);
    step(0, 0, 0, 4, 1);
    step(0, 0, 0, 4, 1);
    for (int n = 0; n < 500; n++)
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 5)), $urandom,
           5'($urandom_range(0, 5)), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, i[4:0], 1); step(0, 0, 0, i[4:0], 1);
      step(0, 0, 0, i[4:0], 1); step(0, 0, 0, i[4:0], 1);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 32'hF0 + i, 4, 0);
    @(negedge clk);
    in_valid = 1; in_vc = 0; sel = 0; out_ready = 0;
    #2 rst = 0;
    #1;
    chk("arst_empty", vc_empty, 4'hF);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) q[i].delete();
    @(negedge clk); rst = 1; in_valid = 0;
    step(1, 0, 32'h55, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
